// File: rtl/i2c_regfile_slave_if.sv
// I2C pin-level bundle for the register-file slave: raw SCL/SDA levels in,
// open-drain SDA pull-down request out.
interface i2c_regfile_slave_if;
    logic scl_di;
    logic sda_di;
    logic sda_pulldown;

    modport slave  (input scl_di, input sda_di, output sda_pulldown);
    modport master (output scl_di, output sda_di, input sda_pulldown);
endinterface

// File: rtl/i2c_regfile_slave.sv
// I2C slave exposing an N_REGS x 8-bit register file with a persistent,
// optionally auto-incrementing register pointer. Oversamples SCL/SDA on clk.
module i2c_regfile_slave #(
    parameter logic [6:0] I2C_ADDRESS = 7'h42,
    parameter int         N_REGS      = 16,
    parameter int         AUTO_INC    = 1,
    localparam int        PTR_W       = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_regfile_slave_if.slave    bus,
    output logic [N_REGS*8-1:0]   regs_q,
    output logic                  reg_wr_stb,
    output logic [PTR_W-1:0]      reg_wr_idx,
    output logic                  reg_rd_stb,
    output logic                  busy,
    output logic                  error_stb,
    output logic [3:0]            debug_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    state_t           state;
    logic [1:0]       scl_sync;
    logic [1:0]       sda_sync;
    logic             scl_d;
    logic             sda_d;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [7:0]       shreg;
    logic [3:0]       bit_cnt;
    logic             rw;
    logic             mst_ack;
    logic             scl_s;
    logic             sda_s;
    logic             scl_rise;
    logic             scl_fall;
    logic             start_det;
    logic             stop_det;
    logic             ack_state;
    logic [7:0]       cur_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_di};
            sda_sync <= {sda_sync[0], bus.sda_di};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign ack_state = state inside {ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK};
    assign cur_byte  = regs_q[{ptr, 3'b000} +: 8];
    assign ptr_next  = (AUTO_INC != 0) ? ptr + PTR_W'(1) : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ptr              <= '0;
            regs_q           <= '0;
            shreg            <= '0;
            bit_cnt          <= '0;
            rw               <= 1'b0;
            mst_ack          <= 1'b1;
            bus.sda_pulldown <= 1'b0;
            reg_wr_stb       <= 1'b0;
            reg_wr_idx       <= '0;
            reg_rd_stb       <= 1'b0;
            error_stb        <= 1'b0;
        end else begin
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
            error_stb  <= 1'b0;
            // START/STOP win over everything and drop any partial byte.
            if (start_det || stop_det) begin
                error_stb        <= ack_state;
                bus.sda_pulldown <= 1'b0;
                bit_cnt          <= '0;
                state            <= start_det ? ADDR : IDLE;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        // Bits are sampled on rises; the byte closes on the
                        // fall after the 8th rise, so the START's own SCL fall
                        // is never miscounted as a bit.
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == I2C_ADDRESS) begin
                                    rw               <= shreg[0];
                                    bus.sda_pulldown <= 1'b1;
                                    state            <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == PTR) begin
                                ptr              <= shreg[PTR_W-1:0];
                                bus.sda_pulldown <= 1'b1;
                                state            <= PTR_ACK;
                            end else begin
                                regs_q[{ptr, 3'b000} +: 8] <= shreg;
                                reg_wr_stb       <= 1'b1;
                                reg_wr_idx       <= ptr;
                                ptr              <= ptr_next;
                                bus.sda_pulldown <= 1'b1;
                                state            <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shreg            <= cur_byte;
                                reg_rd_stb       <= 1'b1;
                                bus.sda_pulldown <= ~cur_byte[7];
                                bit_cnt          <= '0;
                                state            <= RDATA;
                            end else begin
                                bus.sda_pulldown <= 1'b0;
                                state            <= (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bus.sda_pulldown <= 1'b0;
                                ptr              <= ptr_next;
                                bit_cnt          <= '0;
                                state            <= RDATA_ACK;
                            end else begin
                                shreg            <= {shreg[6:0], 1'b0};
                                bus.sda_pulldown <= ~shreg[6];
                                bit_cnt          <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            mst_ack <= sda_s;
                        end else if (scl_fall) begin
                            if (!mst_ack) begin
                                shreg            <= cur_byte;
                                reg_rd_stb       <= 1'b1;
                                bus.sda_pulldown <= ~cur_byte[7];
                                state            <= RDATA;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (state != IDLE);
    assign debug_state = state;

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: bit-banged I2C master, array model of the
// register file and pointer, directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_i2c_regfile_slave;
    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_regfile_slave_if bus ();
    i2c_regfile_slave_if bus2 ();
    assign bus.scl_di  = scl_m;
    assign bus.sda_di  = sda_m & ~bus.sda_pulldown;
    assign bus2.scl_di = scl_m;
    assign bus2.sda_di = sda_m & ~bus2.sda_pulldown;

    logic [127:0] regs_q, regs_q2;
    logic         reg_wr_stb, reg_rd_stb, busy, error_stb;
    logic [3:0]   reg_wr_idx, debug_state;
    logic         reg_wr_stb2, reg_rd_stb2, busy2, error_stb2;
    logic [3:0]   reg_wr_idx2, debug_state2;

    i2c_regfile_slave #(.I2C_ADDRESS(7'h42), .N_REGS(16), .AUTO_INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .regs_q(regs_q),
        .reg_wr_stb(reg_wr_stb), .reg_wr_idx(reg_wr_idx), .reg_rd_stb(reg_rd_stb),
        .busy(busy), .error_stb(error_stb), .debug_state(debug_state));

    i2c_regfile_slave #(.I2C_ADDRESS(7'h42), .N_REGS(16), .AUTO_INC(0)) dut_ni (
        .clk(clk), .rst_n(rst2_n), .bus(bus2), .regs_q(regs_q2),
        .reg_wr_stb(reg_wr_stb2), .reg_wr_idx(reg_wr_idx2), .reg_rd_stb(reg_rd_stb2),
        .busy(busy2), .error_stb(error_stb2), .debug_state(debug_state2));

    always #5 clk = ~clk;

    int unsigned pd_cnt = 0, ign_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [3:0]  wr_log[$];
    always @(negedge clk) begin
        if (reg_wr_stb) wr_log.push_back(reg_wr_idx);
        if (reg_rd_stb) rd_cnt++;
        if (error_stb) err_cnt++;
        if (bus.sda_pulldown) pd_cnt++;
        if (debug_state == 4'd9) ign_cnt++;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mregs[16];
    logic [3:0] mptr = '0;
    logic [7:0] wbuf[16];
    logic [7:0] rbuf[16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = mregs[i];
        return v;
    endfunction

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); ack = bus.sda_di; qw(); scl_m = 1'b0; qw();
    endtask

    task automatic recv_bits(input int n, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < n; i++) begin
            sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); b = {b[6:0], bus.sda_di}; qw(); scl_m = 1'b0; qw();
        end
    endtask

    task automatic ack_phase(input logic a);
        sda_m = a; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
    endtask

    task automatic wr_txn(input logic [7:0] p, input int n);
        int   acks = 0;
        logic a;
        i2c_start();
        send_byte(8'h84, a); if (!a) acks++;
        send_byte(p, a);     if (!a) acks++;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], a); if (!a) acks++;
        end
        i2c_stop();
        mptr = p[3:0];
        for (int i = 0; i < n; i++) begin
            mregs[mptr] = wbuf[i];
            mptr = mptr + 4'd1;
        end
        chk("wr_acks", 128'(acks), 128'(n + 2));
        chk("wr_regs", regs_q, model_vec());
    endtask

    task automatic rd_txn(input logic setp, input logic [7:0] p, input int n);
        int   acks = 0;
        logic a;
        i2c_start();
        if (setp) begin
            send_byte(8'h84, a); if (!a) acks++;
            send_byte(p, a);     if (!a) acks++;
            mptr = p[3:0];
            i2c_start();
        end
        send_byte(8'h85, a); if (!a) acks++;
        for (int i = 0; i < n; i++) begin
            recv_bits(8, rbuf[i]);
            ack_phase(i == n - 1);
            chk("rd_byte", 128'(rbuf[i]), 128'(mregs[mptr]));
            mptr = mptr + 4'd1;
        end
        i2c_stop();
        chk("rd_acks", 128'(acks), setp ? 128'd3 : 128'd1);
    endtask

    initial begin
        int unsigned  ws, rs, es, ps, is;
        logic         a;
        logic [7:0]   b;
        logic [127:0] exp2;

        for (int i = 0; i < 16; i++) mregs[i] = '0;
        repeat (5) @(negedge clk);
        chk("rst_regs", regs_q, '0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_state", 128'(debug_state), 128'd0);
        chk("rst_pd", 128'(bus.sda_pulldown), 128'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Distinct seed values; 16 bytes from pointer 0 also wraps it back to 0.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h30 + 8'(i);
        wr_txn(8'h00, 16);

        ws = wr_log.size();
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        wr_txn(8'h03, 2);
        chk("w_reg3", 128'(regs_q[31:24]), 128'hA5);
        chk("w_reg4", 128'(regs_q[39:32]), 128'h5A);
        chk("w_stb_cnt", 128'(wr_log.size() - ws), 128'd2);
        chk("w_idx0", 128'(wr_log[ws]), 128'd3);
        chk("w_idx1", 128'(wr_log[ws+1]), 128'd4);
        rd_txn(1'b0, 8'h00, 1);
        chk("w_ptr5", 128'(rbuf[0]), 128'h35);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        wr_txn(8'h0F, 2);
        rs = rd_cnt;
        rd_txn(1'b1, 8'h0F, 2);
        chk("wrap_b0", 128'(rbuf[0]), 128'h11);
        chk("wrap_b1", 128'(rbuf[1]), 128'h22);
        chk("wrap_rdstb", 128'(rd_cnt - rs), 128'd2);
        rd_txn(1'b0, 8'h00, 1);
        chk("wrap_ptr1", 128'(rbuf[0]), 128'h31);

        ps = pd_cnt; is = ign_cnt;
        i2c_start();
        send_byte(8'h86, a); chk("mis_nack_addr", 128'(a), 128'd1);
        send_byte(8'hFF, a); chk("mis_nack_data", 128'(a), 128'd1);
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("mis_pd", 128'(pd_cnt - ps), 128'd0);
        chk("mis_ignore", 128'(ign_cnt > is), 128'd1);
        chk("mis_regs", regs_q, model_vec());
        chk("mis_busy", 128'(busy), 128'd0);

        ws = wr_log.size();
        i2c_start();
        send_byte(8'h84, a);
        send_byte(8'h02, a);
        send_bits(8'hFF, 3);
        i2c_stop();
        repeat (4) @(negedge clk);
        mptr = 4'd2;
        chk("abort_nowr", 128'(wr_log.size() - ws), 128'd0);
        chk("abort_regs", regs_q, model_vec());
        chk("abort_state", 128'(debug_state), 128'd0);
        rd_txn(1'b0, 8'h00, 1);
        chk("abort_ptr2", 128'(rbuf[0]), 128'h32);

        // STOP inside the master's ACK bit of a read.
        es = err_cnt;
        i2c_start();
        send_byte(8'h85, a);
        recv_bits(8, b);
        chk("err_byte", 128'(b), 128'(mregs[mptr]));
        mptr = mptr + 4'd1;
        sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw();
        repeat (4) @(negedge clk);
        chk("err_stb", 128'(err_cnt - es), 128'd1);
        chk("err_busy", 128'(busy), 128'd0);

        rst2_n = 1'b1;
        repeat (4) @(negedge clk);
        wbuf[0] = 8'h10; wbuf[1] = 8'h20;
        wr_txn(8'h01, 2);
        exp2 = '0;
        exp2[15:8] = 8'h20;
        chk("noinc_regs", regs_q2, exp2);
        rst2_n = 1'b0;

        wbuf[0] = 8'h00;
        wr_txn(8'h07, 1);
        i2c_start();
        send_byte(8'h84, a);
        send_byte(8'h07, a);
        i2c_start();
        send_byte(8'h85, a);
        recv_bits(3, b);
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw();
        chk("rst_mid_pd_on", 128'(bus.sda_pulldown), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pd_off", 128'(bus.sda_pulldown), 128'd0);
        sda_m = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mptr = '0;
        chk("rst_mid_regs", regs_q, '0);
        chk("rst_mid_state", 128'(debug_state), 128'd0);

        for (int t = 0; t < 20; t++) begin
            int         n;
            logic [7:0] p;
            n = int'($urandom_range(1, 3));
            p = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                wr_txn(p, n);
            end else begin
                rd_txn(1'($urandom_range(0, 1)), p, n);
            end
        end
        chk("final_regs", regs_q, model_vec());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
